clause_scanner: RTL
===================

// Module: clause_scanner
// PURPOSE
//  Sweeps the clause memory PL read port one clause per cycle, evaluates each 3-literal clause
//  against the current variable assignment, counts unsatisfied clauses and captures the first
//  unsatisfied clause found from a rotating start offset. Sits directly downstream of the clause
//  memory; its result feeds the WalkSAT flip-selection stage.
// PARAMETERS
//  CLAUSE_WIDTH  36    clause word width; must equal NUM_LITS*LIT_WIDTH (elaboration check)
//  CLAUSE_DEPTH  2048  clause memory depth; AW = $clog2(CLAUSE_DEPTH)
//  NUM_LITS      3     literals per clause
//  LIT_WIDTH     12    literal = {neg[11], var_idx[10:0]}; var_idx 0 = empty slot
// PORTS
//  clk_i            in   1             clock
//  rst_i            in   1             synchronous, active-high reset
//  start_i          in   1             start a scan; sampled only in IDLE
//  num_clauses_i    in   AW+1          N clauses to scan (0..CLAUSE_DEPTH), sampled with start_i
//  start_offset_i   in   AW            first address scanned, sampled with start_i
//  clause_address_o out  AW            to clause memory PL read address
//  clause_i         in   CLAUSE_WIDTH  from clause memory (combinational read of clause_address_o)
//  var_addr_o       out  NUM_LITS*11   per-literal variable index to assignment store
//  var_val_i        in   NUM_LITS      per-literal variable value (combinational read)
//  busy_o           out  1             high from cycle after start until done_o cycle inclusive
//  done_o           out  1             one-cycle pulse; results valid from this cycle
//  sat_o            out  1             1 = no unsatisfied clause found
//  unsat_count_o    out  AW+1          number of unsatisfied clauses
//  sel_valid_o      out  1             sel_addr_o/sel_clause_o hold a captured clause
//  sel_addr_o       out  AW            address of first unsatisfied clause in scan order
//  sel_clause_o     out  CLAUSE_WIDTH  contents of that clause
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 except sat_o=1; var_addr_o=0, clause_address_o=0.
//  FSM IDLE->SCAN (start_i, N>0) | IDLE->FINISH (start_i, N=0); SCAN->DRAIN after N issues;
//   DRAIN->FINISH; FINISH->IDLE. start_i outside IDLE ignored.
//  Start sampled at edge T: SCAN cycles T+1..T+N, DRAIN T+N+1, done_o=1 at T+N+2. N=0: done at T+1.
//  Stage 0 (SCAN): clause_address_o = base+i; i=0..N-1; base = start_offset_i, forced to 0 if
//   >= N; address wraps from N-1 to 0 (not at CLAUSE_DEPTH). clause_i registered with address.
//  Stage 1 (cycle after issue): var_addr_o driven from registered literal indices; literal true
//   iff idx!=0 and (var_val_i ^ neg); clause unsat iff no literal true (empty clause = unsat).
//  Unsat: unsat_count increments (saturates at CLAUSE_DEPTH, cannot overflow AW+1); first unsat
//   sets sel_valid and latches address/clause; later unsat clauses do not overwrite.
//  On start: unsat_count, sel_valid cleared and sat_o set to 1 in cycle T+1; sat_o =
//   (unsat_count==0) updated at FINISH. Results held until next accepted start.
//  rst_i mid-scan: abort immediately to reset values; no done_o pulse.
//  Clause memory or assignment writes during a scan: results undefined (software's responsibility).
//  var_addr_o = 0 outside stage-1-valid cycles.
// STRUCTURE
//  Package sat_pkg: LIT_WIDTH, NUM_LITS, literal field positions (LIT_NEG_BIT, LIT_IDX_MSB/LSB),
//   scanner state enum {IDLE,SCAN,DRAIN,FINISH}.
//  Sub-module clause_eval: combinational clause + var_val_i -> unsat flag; FSM, address
//   counter, pipeline register and result capture stay in clause_scanner.
// TESTING
//  N=4, offset 0, all clauses satisfied -> done at T+6, sat_o=1, count=0, sel_valid_o=0.
//  N=4, offset 2, clauses 1 and 3 unsat -> scan order 2,3,0,1; sel_addr_o=3, count=2, sat_o=0.
//  N=0 start -> done_o at T+1, sat_o=1, count=0, no clause_address_o activity.
//  Clause {12'h000,12'h805,12'h003}, var5=1, var3=0 -> unsat; flip var3=1 -> sat.
//  offset 7 >= N=5 -> scan starts at 0; start_i pulsed while busy -> ignored, single done_o.
//  rst_i at 3rd SCAN cycle -> next cycle all outputs at reset values, no done_o; fresh start works.

Source files
------------

// File: rtl/sat_pkg.sv
// Shared literal layout and scanner state encoding for the SAT clause pipeline.
package sat_pkg;

    localparam int unsigned LIT_WIDTH   = 12;
    localparam int unsigned NUM_LITS    = 3;
    localparam int unsigned LIT_NEG_BIT = 11;
    localparam int unsigned LIT_IDX_MSB = 10;
    localparam int unsigned LIT_IDX_LSB = 0;
    localparam int unsigned IDX_WIDTH   = LIT_IDX_MSB - LIT_IDX_LSB + 1;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DRAIN,
        FINISH
    } scan_state_e;

endpackage

// File: rtl/clause_eval.sv
// Combinational evaluation of one clause against the per-literal variable values.
module clause_eval #(
    parameter int unsigned NUM_LITS  = 3,
    parameter int unsigned LIT_WIDTH = 12
) (
    input  logic [NUM_LITS*LIT_WIDTH-1:0]     clause_i,
    input  logic [NUM_LITS-1:0]               var_val_i,
    output logic [NUM_LITS*(LIT_WIDTH-1)-1:0] var_idx_o,
    output logic                              unsat_o
);
    import sat_pkg::*;

    logic [NUM_LITS-1:0] lit_true;

    // An index of zero marks an empty slot, which can never satisfy the clause.
    always_comb begin
        lit_true  = '0;
        var_idx_o = '0;
        for (int unsigned l = 0; l < NUM_LITS; l++) begin
            var_idx_o[l*IDX_WIDTH +: IDX_WIDTH] = clause_i[l*LIT_WIDTH + LIT_IDX_LSB +: IDX_WIDTH];
            lit_true[l] = (clause_i[l*LIT_WIDTH + LIT_IDX_LSB +: IDX_WIDTH] != '0) &&
                          (var_val_i[l] ^ clause_i[l*LIT_WIDTH + LIT_NEG_BIT]);
        end
    end

    assign unsat_o = ~|lit_true;

endmodule

// File: rtl/clause_scanner.sv
// Sweeps the clause memory once per start, counting unsatisfied clauses and capturing
// the first one found in rotated scan order for the flip-selection stage.
module clause_scanner #(
    parameter  int unsigned CLAUSE_WIDTH = 36,
    parameter  int unsigned CLAUSE_DEPTH = 2048,
    parameter  int unsigned NUM_LITS     = 3,
    parameter  int unsigned LIT_WIDTH    = 12,
    localparam int unsigned AW           = $clog2(CLAUSE_DEPTH)
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              start_i,
    input  logic [AW:0]                       num_clauses_i,
    input  logic [AW-1:0]                     start_offset_i,
    output logic [AW-1:0]                     clause_address_o,
    input  logic [CLAUSE_WIDTH-1:0]           clause_i,
    output logic [NUM_LITS*(LIT_WIDTH-1)-1:0] var_addr_o,
    input  logic [NUM_LITS-1:0]               var_val_i,
    output logic                              busy_o,
    output logic                              done_o,
    output logic                              sat_o,
    output logic [AW:0]                       unsat_count_o,
    output logic                              sel_valid_o,
    output logic [AW-1:0]                     sel_addr_o,
    output logic [CLAUSE_WIDTH-1:0]           sel_clause_o
);
    import sat_pkg::*;

    if (CLAUSE_WIDTH != NUM_LITS * LIT_WIDTH) begin : g_width_check
        $error("clause_scanner: CLAUSE_WIDTH must equal NUM_LITS*LIT_WIDTH");
    end

    scan_state_e                       state_q;
    logic [AW:0]                       n_q;
    logic [AW:0]                       issued_q;
    logic [AW:0]                       unsat_cnt_q;
    logic [AW:0]                       unsat_cnt_d;
    logic [AW-1:0]                     addr_q;
    logic [AW-1:0]                     s1_addr_q;
    logic [AW-1:0]                     sel_addr_q;
    logic [CLAUSE_WIDTH-1:0]           s1_clause_q;
    logic [CLAUSE_WIDTH-1:0]           sel_clause_q;
    logic                              s1_valid_q;
    logic                              busy_q;
    logic                              done_q;
    logic                              sat_q;
    logic                              sel_valid_q;
    logic [NUM_LITS*(LIT_WIDTH-1)-1:0] lit_idx;
    logic                              s1_unsat;
    logic [AW-1:0]                     base;
    logic                              addr_wrap;

    clause_eval #(
        .NUM_LITS  (NUM_LITS),
        .LIT_WIDTH (LIT_WIDTH)
    ) u_eval (
        .clause_i  (s1_clause_q),
        .var_val_i (var_val_i),
        .var_idx_o (lit_idx),
        .unsat_o   (s1_unsat)
    );

    // An out-of-range offset restarts the sweep at 0; the sweep wraps at N, not at depth.
    assign base      = ({1'b0, start_offset_i} >= num_clauses_i) ? '0 : start_offset_i;
    assign addr_wrap = ({1'b0, addr_q} == n_q - 1'b1);

    always_comb begin
        unsat_cnt_d = unsat_cnt_q;
        if (s1_valid_q && s1_unsat && (unsat_cnt_q < (AW+1)'(CLAUSE_DEPTH))) begin
            unsat_cnt_d = unsat_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            n_q          <= '0;
            issued_q     <= '0;
            unsat_cnt_q  <= '0;
            addr_q       <= '0;
            s1_addr_q    <= '0;
            s1_clause_q  <= '0;
            s1_valid_q   <= 1'b0;
            sel_addr_q   <= '0;
            sel_clause_q <= '0;
            sel_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            sat_q        <= 1'b1;
        end else begin
            done_q      <= 1'b0;
            s1_valid_q  <= 1'b0;
            unsat_cnt_q <= unsat_cnt_d;
            if (s1_valid_q && s1_unsat && !sel_valid_q) begin
                sel_valid_q  <= 1'b1;
                sel_addr_q   <= s1_addr_q;
                sel_clause_q <= s1_clause_q;
            end
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        n_q         <= num_clauses_i;
                        issued_q    <= '0;
                        unsat_cnt_q <= '0;
                        sel_valid_q <= 1'b0;
                        sat_q       <= 1'b1;
                        busy_q      <= 1'b1;
                        if (num_clauses_i == '0) begin
                            state_q <= FINISH;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= SCAN;
                            addr_q  <= base;
                        end
                    end
                end
                SCAN: begin
                    s1_valid_q  <= 1'b1;
                    s1_addr_q   <= addr_q;
                    s1_clause_q <= clause_i;
                    addr_q      <= addr_wrap ? '0 : addr_q + 1'b1;
                    issued_q    <= issued_q + 1'b1;
                    if (issued_q == n_q - 1'b1) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    // The last clause is evaluated this cycle, so use the updated count.
                    state_q <= FINISH;
                    done_q  <= 1'b1;
                    sat_q   <= (unsat_cnt_d == '0);
                end
                FINISH: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign clause_address_o = addr_q;
    assign var_addr_o       = s1_valid_q ? lit_idx : '0;
    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign sat_o            = sat_q;
    assign unsat_count_o    = unsat_cnt_q;
    assign sel_valid_o      = sel_valid_q;
    assign sel_addr_o       = sel_addr_q;
    assign sel_clause_o     = sel_clause_q;

endmodule
